// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state codes,
// the FSM state type and the default performance-counter width.
package pipeline_ctrl_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RUN       = 3'd1;
  localparam logic [2:0] STEP_WAIT = 3'd2;
  localparam logic [2:0] STEP_EXEC = 3'd3;
  localparam logic [2:0] HALTED    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = IDLE,
    ST_RUN       = RUN,
    ST_STEP_WAIT = STEP_WAIT,
    ST_STEP_EXEC = STEP_EXEC,
    ST_HALTED    = HALTED
  } state_t;

  localparam int CANT_BITS_CONTADOR_DEFAULT = 32;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Control bundle between the controller (slave) and the units that feed it
// and consume its enables (master side: debug unit, hazard unit, pipeline).
interface pipeline_stall_controller_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CANT_BITS_CONTADOR = CANT_BITS_CONTADOR_DEFAULT
);
  logic                          i_start;
  logic                          i_debug_mode;
  logic                          i_step;
  logic                          i_bit_burbuja;
  logic                          i_branch_taken_id;
  logic                          i_halt_wb;
  logic                          o_enable_pc;
  logic                          o_enable_if_id;
  logic                          o_enable_pipeline;
  logic                          o_flush_if_id;
  logic                          o_burbuja_id_ex;
  logic                          o_disable_for_exception;
  logic                          o_halted;
  logic [CANT_BITS_CONTADOR-1:0] o_cycle_count;
  logic [CANT_BITS_CONTADOR-1:0] o_stall_count;

  modport master (
    output i_start, i_debug_mode, i_step, i_bit_burbuja, i_branch_taken_id, i_halt_wb,
    input  o_enable_pc, o_enable_if_id, o_enable_pipeline, o_flush_if_id,
           o_burbuja_id_ex, o_disable_for_exception, o_halted, o_cycle_count, o_stall_count
  );

  modport slave (
    input  i_start, i_debug_mode, i_step, i_bit_burbuja, i_branch_taken_id, i_halt_wb,
    output o_enable_pc, o_enable_if_id, o_enable_pipeline, o_flush_if_id,
           o_burbuja_id_ex, o_disable_for_exception, o_halted, o_cycle_count, o_stall_count
  );

endinterface

// File: rtl/contador_saturado.sv
// Saturating up-counter: synchronous clear has priority over increment,
// and the value sticks at all-ones instead of wrapping.
module contador_saturado #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count register: async reset, sync clear, increment until saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (increment && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencing controller: run / single-step / halted mode FSM,
// Mealy decode of stage enables, flush and bubble, plus cycle/stall counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CANT_BITS_CONTADOR = CANT_BITS_CONTADOR_DEFAULT
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  pipeline_stall_controller_if.slave  bus
);

  state_t state_reg;
  state_t state_next;

  logic active;
  logic clear_counters;
  logic stall_cycle;
  logic enable_pc;
  logic enable_if_id;
  logic enable_pipeline;
  logic flush_if_id;
  logic burbuja_id_ex;
  logic disable_for_exception;
  logic [CANT_BITS_CONTADOR-1:0] cycle_count;
  logic [CANT_BITS_CONTADOR-1:0] stall_count;

  // Mode register; reset drops straight back to IDLE regardless of the clock.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-mode logic; start and step pulses only matter in their own states.
  always_comb begin
    state_next     = state_reg;
    clear_counters = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_start) begin
          clear_counters = 1'b1;
          state_next     = bus.i_debug_mode ? ST_STEP_WAIT : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_halt_wb) state_next = ST_HALTED;
      end
      ST_STEP_WAIT: begin
        if (bus.i_step) state_next = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        state_next = bus.i_halt_wb ? ST_HALTED : ST_STEP_WAIT;
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign active      = (state_reg == ST_RUN) || (state_reg == ST_STEP_EXEC);
  assign stall_cycle = active && bus.i_bit_burbuja;

  // Enable decode: a bubble freezes PC and IF/ID and overrides a same-cycle
  // branch, since the branch is re-resolved once the load-use stall clears.
  always_comb begin
    enable_pc             = 1'b0;
    enable_if_id          = 1'b0;
    enable_pipeline       = 1'b0;
    flush_if_id           = 1'b0;
    burbuja_id_ex         = 1'b0;
    disable_for_exception = 1'b1;
    if (active) begin
      disable_for_exception = 1'b0;
      enable_pipeline       = 1'b1;
      if (bus.i_bit_burbuja) begin
        burbuja_id_ex = 1'b1;
      end else begin
        enable_pc    = 1'b1;
        enable_if_id = 1'b1;
        flush_if_id  = bus.i_branch_taken_id;
      end
    end
  end

  contador_saturado #(.WIDTH(CANT_BITS_CONTADOR)) u_cycle_counter (
    .clk       (i_clock),
    .rst       (i_reset),
    .clear     (clear_counters),
    .increment (active),
    .count     (cycle_count)
  );

  contador_saturado #(.WIDTH(CANT_BITS_CONTADOR)) u_stall_counter (
    .clk       (i_clock),
    .rst       (i_reset),
    .clear     (clear_counters),
    .increment (stall_cycle),
    .count     (stall_count)
  );

  assign bus.o_enable_pc             = enable_pc;
  assign bus.o_enable_if_id          = enable_if_id;
  assign bus.o_enable_pipeline       = enable_pipeline;
  assign bus.o_flush_if_id           = flush_if_id;
  assign bus.o_burbuja_id_ex         = burbuja_id_ex;
  assign bus.o_disable_for_exception = disable_for_exception;
  assign bus.o_halted                = (state_reg == ST_HALTED);
  assign bus.o_cycle_count           = cycle_count;
  assign bus.o_stall_count           = stall_count;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central pipeline sequencing controller for the MIPS core. It consumes the bubble request from the hazard detection unit, the ID-stage branch decision and the WB-stage HALT indication. From these it drives the per-stage write enables, the IF/ID flush and the ID/EX bubble insertion. It also implements run / single-step (debug) / halted modes and keeps saturating cycle and stall counters for the debug unit.

## Interface
Parameters:
- CANT_BITS_CONTADOR, 32, width of both performance counters

Ports:
- i_clock  input  1  system clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_start  input  1  one-cycle pulse from debug unit; leaves IDLE
- i_debug_mode  input  1  sampled with i_start: 1 = single-step, 0 = continuous
- i_step  input  1  one-cycle pulse; advances pipeline one clock in step mode
- i_bit_burbuja  input  1  load-use bubble request from hazard detection unit
- i_branch_taken_id  input  1  branch/jump resolved taken in ID
- i_halt_wb  input  1  HALT instruction present in WB this cycle
- o_enable_pc  output  1  PC write enable
- o_enable_if_id  output  1  IF/ID register write enable
- o_enable_pipeline  output  1  write enable for ID/EX, EX/MEM, MEM/WB and register file
- o_flush_if_id  output  1  IF/ID loads a NOP
- o_burbuja_id_ex  output  1  ID/EX control fields forced to zero
- o_disable_for_exception  output  1  to hazard unit; masks bubble requests while pipeline frozen
- o_halted  output  1  core halted
- o_cycle_count  output  CANT_BITS_CONTADOR  active cycles since start
- o_stall_count  output  CANT_BITS_CONTADOR  bubble cycles since start

## Operation
- States (3-bit encoding):
  - IDLE
  - RUN
  - STEP_WAIT
  - STEP_EXEC
  - HALTED
- Active = RUN or STEP_EXEC.
- Transitions:
  - IDLE + i_start → RUN if i_debug_mode=0, else STEP_WAIT; counters cleared to 0 on this edge.
  - RUN + i_halt_wb → HALTED.
  - STEP_WAIT + i_step → STEP_EXEC.
  - STEP_EXEC → HALTED if i_halt_wb, else STEP_WAIT (always exactly one cycle).
  - HALTED is sticky until i_reset.
  - i_start is ignored outside IDLE.
  - i_step is ignored outside STEP_WAIT.
- Outputs in non-active states:
  - all enables, o_flush_if_id and o_burbuja_id_ex = 0
  - o_disable_for_exception = 1
- Outputs in active states (combinational, priority order):
  - i_bit_burbuja=1: o_enable_pc=0, o_enable_if_id=0, o_burbuja_id_ex=1, o_enable_pipeline=1, o_flush_if_id=0. A simultaneous branch is ignored, because the branch is re-evaluated after the stall.
  - else i_branch_taken_id=1: o_enable_pc=1, o_enable_if_id=1, o_flush_if_id=1, o_enable_pipeline=1.
  - else: o_enable_pc, o_enable_if_id and o_enable_pipeline = 1; o_flush_if_id and o_burbuja_id_ex = 0.
  - o_disable_for_exception = 0.
- Halt cycle: in the active cycle with i_halt_wb=1, enables follow the rules above so the HALT commits. All enables drop on the next cycle.
- o_halted = 1 exactly in HALTED.
- Counters:
  - o_cycle_count +1 every active cycle.
  - o_stall_count +1 every active cycle with i_bit_burbuja=1.
  - Both saturate at all-ones and hold in non-active states.

## Timing
- Reset: state=IDLE; counters=0; o_disable_for_exception=1; all other outputs 0. This takes effect immediately, independent of the clock edge.
- Reset mid-operation (any state) → IDLE asynchronously. Counters clear and outputs go to their reset values in the same instant.
- Enable, flush and bubble outputs are Mealy: same-cycle response to i_bit_burbuja and i_branch_taken_id, zero latency.
- State and counters are registered on the i_clock rising edge; mode change is visible one cycle after the triggering pulse.
- Single step: i_step at edge N → exactly one active cycle N+1 → STEP_WAIT at N+2. A step that coincides with a bubble still consumes its one cycle, so the stalled instruction needs a further i_step.
- i_halt_wb and i_step are never both relevant in one state, so no conflict exists.
- i_start held high for several cycles produces a single transition.

## Structure
- Shared package (pipeline_ctrl_pkg): state localparams (IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, HALTED=4) and the default CANT_BITS_CONTADOR.
- One natural sub-module, contador_saturado: parameterized width, with inputs sync clear and increment, and async reset. It is instantiated twice, for cycles and for stalls.
- The FSM and the combinational enable decode stay in the top module.

## Test plan
- Reset then i_start with i_debug_mode=0 → RUN next cycle. All enables 1, o_disable_for_exception=0, o_cycle_count reaches 10 after 10 cycles.
- RUN with i_bit_burbuja=1 for 1 cycle → that cycle o_enable_pc=0, o_enable_if_id=0, o_burbuja_id_ex=1. Same cycle with i_branch_taken_id=1 → o_flush_if_id=0. o_stall_count=1.
- RUN with i_branch_taken_id=1 alone → o_flush_if_id=1 and o_enable_pc=1 that cycle only.
- Step mode: i_start with i_debug_mode=1, then 3 i_step pulses spaced 5 cycles apart → exactly 3 cycles with o_enable_pc=1. o_cycle_count=3.
- i_halt_wb in RUN → enables 1 that cycle, then 0. o_halted=1 and remains 1 despite i_start and i_step.
- Assert i_reset asynchronously mid-RUN with counters at 0x20 → outputs and counters reset immediately, without waiting for a clock edge. A counter preloaded near all-ones saturates at 0xFFFFFFFF.
